link_tx_arbiter: RTL

//  Shares one 64-bit valid/ready inter-FPGA link (parent uplink or grid_1/grid_2 port) among NUM_REQ on-chip sources.

---
 rtl/link_tx_arbiter_pkg.sv | 19 +
 rtl/link_tx_arbiter_if.sv | 30 +++
 rtl/link_tx_arbiter_rr_picker.sv | 26 ++
 rtl/link_tx_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/link_tx_arbiter_pkg.sv
// Shared types and helpers for the link transmit arbiter slice.
package link_tx_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Source-id width, kept at least one bit so a single-source build still has a port.
  function automatic int unsigned src_w(input int unsigned n);
    return ($clog2(n) > 0) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned rr_index(input int unsigned base, input int unsigned off,
                                           input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/link_tx_arbiter_if.sv
// Request-side and link-side signals of the transmit arbiter.
interface link_tx_arbiter_if
  import link_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 64
) ();
  localparam int unsigned SRC_W = src_w(NUM_REQ);

  logic [WIDTH*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]         out_data;
  logic                     out_valid;
  logic                     out_last;
  logic [SRC_W-1:0]         out_src;
  logic                     out_ready;
  logic [31:0]              msg_count;

  modport master (
    output req_data, req_valid, req_last, out_ready,
    input  req_ready, out_data, out_valid, out_last, out_src, msg_count
  );

  modport slave (
    input  req_data, req_valid, req_last, out_ready,
    output req_ready, out_data, out_valid, out_last, out_src, msg_count
  );
endinterface

// File: rtl/link_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_picker
  import link_tx_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned SRC_W   = src_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [SRC_W-1:0]   grant_id,
  output logic               found
);
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      if (!found && req[rr_index(32'(last_grant), off, NUM_REQ)]) begin
        found = 1'b1;
        grant[rr_index(32'(last_grant), off, NUM_REQ)] = 1'b1;
        grant_id = SRC_W'(rr_index(32'(last_grant), off, NUM_REQ));
      end
    end
  end
endmodule

// File: rtl/link_tx_arbiter.sv
// Message-atomic round-robin arbiter sharing one valid/ready link among NUM_REQ sources,
// with a single registered output stage and a completed-message counter.
module link_tx_arbiter
  import link_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 64
) (
  input  logic             clk,
  input  logic             reset,
  link_tx_arbiter_if.slave bus
);
  localparam int unsigned SRC_W = src_w(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [SRC_W-1:0]   owner_q, owner_d;
  logic [SRC_W-1:0]   last_grant_q, last_grant_d;
  logic [SRC_W-1:0]   sel;
  logic [NUM_REQ-1:0] pick_grant;
  logic [SRC_W-1:0]   pick_id;
  logic               pick_found;
  logic [NUM_REQ-1:0] req_ready;
  logic               can_load, accept, sel_last;
  logic [WIDTH-1:0]   sel_data;

  logic [WIDTH-1:0]   out_data_q;
  logic               out_valid_q, out_last_q;
  logic [SRC_W-1:0]   out_src_q;
  logic [31:0]        msg_count_q;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .grant_id   (pick_id),
    .found      (pick_found)
  );

  always_comb begin
    can_load     = !out_valid_q || bus.out_ready;
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    req_ready    = '0;
    accept       = 1'b0;
    sel          = owner_q;
    if (!reset) begin
      unique case (state_q)
        ST_IDLE: begin
          if (can_load && pick_found) begin
            req_ready = pick_grant;
            accept    = 1'b1;
            sel       = pick_id;
          end
        end
        ST_LOCKED: begin
          // Owner keeps the link across bubbles; nobody else is looked at.
          if (can_load && bus.req_valid[owner_q]) begin
            req_ready[owner_q] = 1'b1;
            accept             = 1'b1;
          end
        end
        default: ;
      endcase
    end
    sel_last = bus.req_last[sel];
    sel_data = bus.req_data[sel*WIDTH +: WIDTH];
    if (accept) begin
      if (sel_last) begin
        state_d      = ST_IDLE;
        last_grant_d = sel;
      end else begin
        state_d = ST_LOCKED;
        owner_d = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_grant_q <= SRC_W'(NUM_REQ - 1);
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_src_q    <= '0;
      msg_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      if (accept) begin
        out_data_q  <= sel_data;
        out_valid_q <= 1'b1;
        out_last_q  <= sel_last;
        out_src_q   <= sel;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (out_valid_q && bus.out_ready && out_last_q) begin
        msg_count_q <= msg_count_q + 32'd1;
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_src   = out_src_q;
  assign bus.msg_count = msg_count_q;

endmodule
